// File: rtl/arb_pkg.sv
// Shared definitions for the three-input bus arbiter: FSM encoding, mux
// selection codes, requester count and the rotating-pointer step helper.
package arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int SEL_NONE = 0;
  localparam int SEL_IN1  = 1;
  localparam int SEL_IN2  = 2;
  localparam int SEL_IN3  = 3;

  // Requester index after i, wrapping 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational rotating-priority search over three requests, starting one
// past the last winner and wrapping.
module rr_pick3
  import arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_ptr_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  logic [1:0] probe;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = 2'd0;
    probe   = next_idx(last_ptr_i);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[probe]) begin
        valid_o = 1'b1;
        idx_o   = probe;
      end
      probe = next_idx(probe);
    end
  end

endmodule

// File: rtl/three_input_bus_arbiter.sv
// Round-robin arbiter/sequencer for the 17-bit three-input operand mux, with
// hold-time preemption and a registered output word.
// Optional per-requester grant counters are enabled by ARB_GRANT_COUNT_EN.
module three_input_bus_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = 17,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [2:0]       Req,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  input  logic [WIDTH-1:0] Input3,
  output logic [2:0]       Grant,
  output logic [SEL_W-1:0] Selection,
  output logic [WIDTH-1:0] Output,
  output logic             OutValid,
  output logic [1:0]       OutSource,
  output arb_state_e       DbgState
`ifdef ARB_GRANT_COUNT_EN
  ,
  output logic [47:0]      GrantCount
`endif
);

  // Handshake: a transfer happens in any cycle where Grant[k] and Req[k] are
  // both high; the word appears on Output with OutValid one cycle later.

  arb_state_e       state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       last_ptr_q, last_ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_src_q, out_src_d;

  logic             transfer;
  logic             hold_limit;
  logic             new_grant;
  logic [2:0]       pick_req;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [WIDTH-1:0] sel_data;

  // While owning, last_ptr_q is the owner, so masking the owner out lets the
  // same search serve idle arbitration, release and preemption.
  assign transfer   = (state_q == ST_OWN) && Req[last_ptr_q];
  assign pick_req   = (state_q == ST_OWN) ? (Req & ~grant_q) : Req;
  assign hold_limit = hold_q >= 8'(MAX_HOLD - 1);

  rr_pick3 u_pick (
    .req_i      (pick_req),
    .last_ptr_i (last_ptr_q),
    .valid_o    (pick_valid),
    .idx_o      (pick_idx)
  );

  always_comb begin
    case (last_ptr_q)
      2'd0:    sel_data = Input1;
      2'd1:    sel_data = Input2;
      default: sel_data = Input3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_ptr_d = last_ptr_q;
    hold_d     = hold_q;
    new_grant  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) new_grant = 1'b1;
      end
      ST_OWN: begin
        if (!transfer) begin
          if (pick_valid) begin
            new_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            sel_d   = SEL_W'(SEL_NONE);
            hold_d  = 8'd0;
          end
        end else if (hold_limit && pick_valid) begin
          new_grant = 1'b1;
        end else if (hold_q != 8'(MAX_HOLD)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (new_grant) begin
      state_d    = ST_OWN;
      grant_d    = 3'b001 << pick_idx;
      sel_d      = SEL_W'(SEL_IN1) + SEL_W'(pick_idx);
      last_ptr_d = pick_idx;
      hold_d     = 8'd0;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_src_d   = out_src_q;
    if (transfer) begin
      out_d       = sel_data;
      out_valid_d = 1'b1;
      out_src_d   = last_ptr_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 3'b000;
      sel_q       <= SEL_W'(SEL_NONE);
      last_ptr_q  <= 2'd2;
      hold_q      <= 8'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_ptr_q  <= last_ptr_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

`ifdef ARB_GRANT_COUNT_EN
  logic [15:0] gcnt_q [3];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= 16'd0;
    end else if (new_grant) begin
      gcnt_q[pick_idx] <= gcnt_q[pick_idx] + 16'd1;
    end
  end

  assign GrantCount = {gcnt_q[2], gcnt_q[1], gcnt_q[0]};
`endif

  assign Grant     = grant_q;
  assign Selection = sel_q;
  assign Output    = out_q;
  assign OutValid  = out_valid_q;
  assign OutSource = out_src_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_three_input_bus_arbiter.sv
// Directed bench for three_input_bus_arbiter: hand-computed expected words go
// into a queue, a negedge monitor pops them whenever OutValid is high.
module tb_three_input_bus_arbiter;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   req = 3'b000;
  logic [W-1:0] in1 = '0, in2 = '0, in3 = '0;
  logic [2:0]   grant;
  logic [3:0]   sel;
  logic [W-1:0] out_w;
  logic         out_valid;
  logic [1:0]   out_src;
  logic         dbg_state;
`ifdef ARB_GRANT_COUNT_EN
  logic [47:0]  grant_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];

  three_input_bus_arbiter #(.WIDTH(W), .SEL_W(4), .MAX_HOLD(2)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .Req       (req),
    .Input1    (in1),
    .Input2    (in2),
    .Input3    (in3),
    .Grant     (grant),
    .Selection (sel),
    .Output    (out_w),
    .OutValid  (out_valid),
    .OutSource (out_src),
    .DbgState  (dbg_state)
`ifdef ARB_GRANT_COUNT_EN
    ,
    .GrantCount(grant_count)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checks and driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic [2:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a cycle that is known to be a transfer and queue its output word.
  task automatic xfer(input logic [2:0] r, input logic [1:0] src, input logic [W-1:0] data);
    exp_q.push_back({src, data});
    cycle(r);
  endtask

  task automatic check_gs(input string name, input logic [2:0] g, input logic [3:0] s);
    check({name, "_grant"}, 32'(grant), 32'(g));
    check({name, "_sel"}, 32'(sel), 32'(s));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      logic [W+1:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word actual=src%0d/%0d required=none", out_src, out_w);
      end else begin
        e = exp_q.pop_front();
        if ({out_src, out_w} !== e) begin
          bad++;
          $display("FAIL out_word actual=src%0d/%0d required=src%0d/%0d",
                   out_src, out_w, e[W+1:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    in1 = 17'd42; in2 = 17'd65; in3 = 17'd85;
    repeat (2) @(negedge clk);
    check_gs("reset", 3'b000, 4'd0);
    check("reset_out", 32'(out_w), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_src", 32'(out_src), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cycle(3'b000);
      check_gs("idle", 3'b000, 4'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
    end

    // Single requester 0
    cycle(3'b001);
    check_gs("single_first", 3'b001, 4'd1);
    check("single_first_valid", 32'(out_valid), 32'd0);
    xfer(3'b001, 2'd0, 17'd42);
    xfer(3'b001, 2'd0, 17'd42);
    cycle(3'b000);
    check_gs("single_drop", 3'b000, 4'd0);
    check("single_drop_valid", 32'(out_valid), 32'd0);
    check("single_drop_hold", 32'(out_w), 32'd42);
    check("single_drop_state", 32'(dbg_state), 32'd0);

    // Round robin with MAX_HOLD=2; last winner was 0 so requester 1 starts
    cycle(3'b111);
    check_gs("rr_start", 3'b010, 4'd2);
    xfer(3'b111, 2'd1, 17'd65);
    xfer(3'b111, 2'd1, 17'd65);
    check_gs("rr_to2", 3'b100, 4'd3);
    xfer(3'b111, 2'd2, 17'd85);
    xfer(3'b111, 2'd2, 17'd85);
    check_gs("rr_to0", 3'b001, 4'd1);
    xfer(3'b111, 2'd0, 17'd42);
    xfer(3'b111, 2'd0, 17'd42);
    check_gs("rr_to1", 3'b010, 4'd2);
    xfer(3'b111, 2'd1, 17'd65);
    xfer(3'b111, 2'd1, 17'd65);
    check_gs("rr_wrap2", 3'b100, 4'd3);
    cycle(3'b000);
    check_gs("rr_release", 3'b000, 4'd0);

    // Handoff without bubble: owner 1 drops while 2 waits
    cycle(3'b010);
    check_gs("ho_own1", 3'b010, 4'd2);
    xfer(3'b110, 2'd1, 17'd65);
    cycle(3'b100);
    check_gs("ho_to2", 3'b100, 4'd3);
    check("ho_gap_valid", 32'(out_valid), 32'd0);
    check("ho_gap_hold", 32'(out_w), 32'd65);
    xfer(3'b100, 2'd2, 17'd85);
    check("ho_valid", 32'(out_valid), 32'd1);
    cycle(3'b000);

    // Hold saturation: sole requester keeps the grant
    cycle(3'b001);
    check_gs("sat_grant", 3'b001, 4'd1);
    for (int i = 0; i < 19; i++) begin
      xfer(3'b001, 2'd0, 17'd42);
      check("sat_hold_grant", 32'(grant), 32'd1);
    end
    xfer(3'b011, 2'd0, 17'd42);
    check_gs("sat_preempt", 3'b010, 4'd2);
    xfer(3'b010, 2'd1, 17'd65);
    cycle(3'b000);

    // Reset mid-transfer
    cycle(3'b010);
    check_gs("mid_grant", 3'b010, 4'd2);
    xfer(3'b010, 2'd1, 17'd65);
    xfer(3'b010, 2'd1, 17'd65);
    req = 3'b010;
    #2 rst_n = 1'b0;
    #1;
    check_gs("mid_reset", 3'b000, 4'd0);
    check("mid_reset_out", 32'(out_w), 32'd0);
    check("mid_reset_valid", 32'(out_valid), 32'd0);
    check("mid_reset_src", 32'(out_src), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(3'b011);
    check_gs("post_reset_first", 3'b001, 4'd1);
    xfer(3'b001, 2'd0, 17'd42);
    cycle(3'b000);
    cycle(3'b000);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/three_input_bus_arbiter.md
Name: three_input_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 17-bit three-input operand mux between three requesters.
- Drives the mux Selection code and per-requester Grant lines, enforces a maximum hold time, and registers the selected word with a valid strobe.
- Sits in front of the ThreeInputsOr3HardWiredMuxes datapath and replaces static Selection wiring.

Parameters:
- WIDTH, 17, data width of each input and of Output.
- SEL_W, 4, width of the Selection code (matches the mux).
- MAX_HOLD, 8, maximum consecutive transfer cycles for one owner while others wait; legal range 1..255.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- Req  input  3  request per requester; bit k = requester k.
- Input1  input  WIDTH  data of requester 0.
- Input2  input  WIDTH  data of requester 1.
- Input3  input  WIDTH  data of requester 2.
- Grant  output  3  one-hot grant, registered.
- Selection  output  SEL_W  mux code: 0 none, 1/2/3 = Input1/2/3.
- Output  output  WIDTH  registered selected data.
- OutValid  output  1  Output holds a transferred word this cycle.
- OutSource  output  2  index of the requester that produced Output.

Behaviour:
- Reset (async, Reset_n=0): Grant=0, Selection=0, Output=0, OutValid=0, OutSource=0, state IDLE, HoldCnt=0, LastPtr=2, so requester 0 has first priority.
- FSM states:
  - IDLE: no grant.
  - OWN: exactly one Grant bit set.
- Arbitration: search order starts at LastPtr+1 mod 3 and wraps. The first set Req wins. LastPtr is updated to the winner when the grant issues.
- IDLE -> OWN: on any Req, Grant and Selection (=winner+1) register at the next edge. Grant latency is 1 cycle.
- Transfer cycle: Grant[k]=1 and Req[k]=1. At the next edge, Output <= selected Input, OutValid <= 1, OutSource <= k. Output latency from transfer is 1 cycle.
- OutValid is 0 in any cycle following a non-transfer cycle. Output holds its last value.
- HoldCnt: increments on each transfer cycle, saturates at MAX_HOLD, and clears on any grant change.
- Release: when Grant[k]=1 and Req[k]=0, arbitrate among the others in the same cycle.
  - Others pending: the new grant issues at the next edge, with no idle bubble.
  - None pending: go to IDLE and drive Grant=0, Selection=0.
- Preemption: when HoldCnt = MAX_HOLD-1 on a transfer cycle and another Req is set, that transfer completes and the grant moves to the next requester at the next edge.
- No other Req at the hold limit: the owner keeps the grant and HoldCnt stays saturated.
- Simultaneous release, new requests and preemption resolve through the single rotating search. Grant is never multi-hot and never changes without Selection changing on the same edge.
- Reset asserted mid-transfer: all outputs clear immediately. A word in flight is dropped.
- Selection codes 4..15 are never driven.

Optional Feature:
- Macro: ARB_GRANT_COUNT_EN.
- With the macro defined:
  - Add output GrantCount (3x16 bits packed, 48 wide).
  - Each counter increments on every new grant issued to its requester and wraps at 0xFFFF.
  - Counters clear on reset.
- Without the macro: the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package arb_pkg:
  - FSM state encoding (IDLE=0, OWN=1).
  - Selection constants SEL_NONE=0, SEL_IN1=1, SEL_IN2=2, SEL_IN3=3.
  - Requester count NUM_REQ=3.
- One natural sub-module, rr_pick3: combinational rotating priority search taking Req and LastPtr and returning a valid flag plus winner index. The FSM, counters and output register stay in the top.

Test Plan:
- Reset then idle: Reset_n=0 -> all outputs 0. Release with Req=0 for 5 cycles -> Grant=0, Selection=0, OutValid=0.
- Single requester: Input1=42, Req=001 for 3 cycles -> Grant=001 and Selection=1 from cycle 1. OutValid=1, Output=42, OutSource=0 from cycle 2. Req drop -> Grant=0 next edge.
- Round robin: Input1=42, Input2=65, Input3=85, Req=111 held, MAX_HOLD=2 -> Output sequence 42,42,65,65,85,85,42... and Selection 1,2,3 rotating.
- Handoff without bubble: owner 1 (Input2=65) drops Req while Req[2]=1 -> Grant=100 and Selection=3 on the next edge. Output=85 valid one cycle later with no gap cycle beyond the release.
- Hold saturation: only Req[0]=1 for 20 cycles with MAX_HOLD=8 -> grant held throughout. Raise Req[1] at cycle 20 -> grant moves to 010 on the next edge.
- Reset mid-transfer: Req=010 streaming 65, pull Reset_n low between edges -> Grant, Selection, Output and OutValid go to 0 immediately. After release the first grant goes to requester 0 if Req=011.
